// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Multiplexed seven-segment driver. It scans NUM_DIGITS hex
//            digits onto one segment bus and drives one anode per digit.
//            Digit loads are double-buffered and swapped in on frame wrap.
//            Supports per-digit DP and blanking, and leading-zero
//            suppression.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0,
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [c_idx_w-1:0]      digit_idx,
  output logic                    frame_tick
);

  localparam int                    c_cnt_w    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [6:0]            c_seg_pol  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] c_an_pol   = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [c_cnt_w-1:0]      r_cnt;
  logic [c_idx_w-1:0]      r_idx;
  logic                    r_frame_tick;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_tc;
  logic                    w_wrap;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_zero_run;
  logic                    w_blank;

  // Hex nibble to active-high segment pattern, seg[6]=A .. seg[0]=G.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 7'h7E;
      4'h1: f_decode = 7'h30;
      4'h2: f_decode = 7'h6D;
      4'h3: f_decode = 7'h79;
      4'h4: f_decode = 7'h33;
      4'h5: f_decode = 7'h5B;
      4'h6: f_decode = 7'h5F;
      4'h7: f_decode = 7'h70;
      4'h8: f_decode = 7'h7F;
      4'h9: f_decode = 7'h7B;
      4'hA: f_decode = 7'h77;
      4'hB: f_decode = 7'h1F;
      4'hC: f_decode = 7'h4E;
      4'hD: f_decode = 7'h3D;
      4'hE: f_decode = 7'h4F;
      default: f_decode = 7'h47;
    endcase
  endfunction

  assign w_tc   = (r_cnt == c_cnt_last);
  assign w_wrap = w_tc && (r_idx == c_idx_last);

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign w_nib[gi] = r_act_digits[4*gi +: 4];
    end
  endgenerate

  // Leading-zero mask: walk down from the top digit while nibbles stay zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (w_nib[i] == 4'h0);
      if (i > 0) w_lz[i] = lz_en && w_zero_run;
    end
  end

  assign w_blank = r_act_blank[r_idx] | w_lz[r_idx];

  // Refresh divider, digit scan pointer and frame-wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap;
      if (w_tc) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  // Double buffer: loads land in shadow and are promoted only on frame
  // wrap. A load coinciding with the wrap goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_digits  <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '0;
      r_pending    <= 1'b0;
      r_act_digits <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
    end else if (w_wrap) begin
      r_pending <= 1'b0;
      if (load) begin
        r_act_digits <= digits_in;
        r_act_dp     <= dp_in;
        r_act_blank  <= blank_in;
      end else if (r_pending) begin
        r_act_digits <= r_sh_digits;
        r_act_dp     <= r_sh_dp;
        r_act_blank  <= r_sh_blank;
      end
    end else if (load) begin
      r_sh_digits <= digits_in;
      r_sh_dp     <= dp_in;
      r_sh_blank  <= blank_in;
      r_pending   <= 1'b1;
    end
  end

  // Registered display outputs for the digit currently selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_dp  <= 1'b0;
      r_an  <= '0;
    end else begin
      r_seg <= w_blank ? 7'h00 : f_decode(w_nib[r_idx]);
      r_dp  <= !w_blank && r_act_dp[r_idx];
      r_an  <= w_blank ? '0 : (NUM_DIGITS'(1) << r_idx);
    end
  end

  assign seg        = r_seg ^ c_seg_pol;
  assign dp         = r_dp ^ SEG_ACTIVE_LOW;
  assign an         = r_an ^ c_an_pol;
  assign digit_idx  = r_idx;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
